dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters.
  - M0: CPU M-stage load/store.
  - M1: debug/DMA loader.
- Memory port is word-addressed with 4-bit byte enables; reads return 1 cycle after the access cycle.
- Round-robin arbitration with a bounded burst length, so neither requester starves.
- Sits between the pipeline's data port, the DMA engine and the data RAM.

Parameters:
- MAX_BURST, 4, max consecutive beats granted to one master while the other is requesting (>=1).
- CNT_W, 3, width of the burst counter; must hold MAX_BURST.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk; 0 = reset.
- m0_req  in  1  M0 access request; held with its payload until granted.
- m0_addr  in  32  M0 byte address.
- m0_wdata  in  32  M0 write data, already byte-lane aligned.
- m0_byteen  in  4  M0 byte enables; 0000 = word read.
- m0_gnt  out  1  M0 access performed this cycle.
- m0_rvalid  out  1  M0 read data valid.
- m0_rdata  out  32  M0 read data.
- m1_req, m1_addr, m1_wdata, m1_byteen, m1_gnt, m1_rvalid, m1_rdata: same as M0, for M1.
- mem_addr  out  32  RAM address, forced to addr & 32'hfffffffc.
- mem_wdata  out  32  RAM write data.
- mem_byteen  out  4  RAM byte enables; nonzero = write.
- mem_rd  out  1  RAM read strobe.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_rd.
- err  out  1  alignment-error pulse (see Optional Feature).

Behaviour:
- State registers:
  - cur: last-served master. Reset value 1, so M0 wins the first tie.
  - cnt: consecutive beats granted to cur. Reset value 0.
  - rsel, rpend: pending-read tracking. Reset value 0.
- Grant decision is combinational within the cycle (Mealy); a grant and the RAM access happen in the same cycle.
  - Neither req: no grant; cnt<=0; cur unchanged.
  - One req: grant it. If it equals cur, cnt<=min(cnt+1,MAX_BURST); otherwise cur<=it, cnt<=1.
  - Both req, cnt!=0 and cnt<MAX_BURST: grant cur; cnt+1.
  - Both req, otherwise: grant !cur; cur<=!cur; cnt<=1.
- At most one gnt is high per cycle. A master whose req is low is never granted.
- Granted master's payload drives the mem_* outputs.
  - mem_rd = (byteen==0).
  - mem_byteen = byteen.
- When no master is granted: mem_byteen=0, mem_rd=0, mem_addr=0, mem_wdata=0.
- Read return:
  - A granted read at cycle t gives mx_rvalid=1 at t+1, with mx_rdata = mem_rdata.
  - At all other times rvalid=0 and rdata=0.
  - Writes produce no rvalid.
- Back-to-back reads from either master are fully pipelined, one beat per cycle.
- A master may drop req while not granted (withdraw); no side effect.
- While reset is low:
  - all gnt=0, mem_byteen=0, mem_rd=0, rvalid=0, err=0;
  - a read granted in the cycle before reset produces no rvalid.
- Reset release: the first tie goes to M0.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined: a granted access is legal only for these combinations:
  - 1111 or 0000 with addr[1:0]=00;
  - 0011 with addr[1:0]=00, or 1100 with addr[1:0]=10;
  - a single-byte enable whose lane equals addr[1:0].
- Defined, illegal access behaviour:
  - it is still granted and still consumes a beat in cnt;
  - mem_byteen=0 and mem_rd=0 that cycle;
  - err=1 at t+1;
  - if it was a read, rvalid=1 at t+1 with rdata=0.
- Undefined: no checking; payload passes through; err tied 0.

Test Plan:
- Reset low for 2 cycles with m0_req=1: all gnt=0, mem_byteen=0. Release reset, m0 writes addr 0x10, byteen 1111, data 0xDEADBEEF: m0_gnt=1 and mem_byteen=1111 in the same cycle.
- m0 reads 0x10 with RAM holding 0xDEADBEEF: mem_rd=1 at t; m0_rvalid=1, m0_rdata=0xDEADBEEF at t+1; m1_rvalid=0.
- Both req from reset, tie: grants go M0 first, then M1, then M0 alternately on each fresh contention.
- M1 streams 10 beats while M0 holds req from beat 2, MAX_BURST=4: M1 gets 4 consecutive grants, then M0 1, then M1 4, etc.; M0 never waits more than 4 cycles.
- M0 read granted at t, reset low at t+1: m0_rvalid stays 0.
- With DM_ALIGN_CHECK_EN: m1 byteen 1111, addr 0x22: mem_byteen=0 and err=1 next cycle. Without the macro: mem_byteen=1111, mem_addr=0x20, err=0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one word-addressed RAM port between
// M0 (CPU load/store) and M1 (debug/DMA loader) with round-robin arbitration
// and a bounded burst length. Grant is Mealy (same cycle as the RAM access);
// read data returns one cycle later.
// Optional alignment checking is enabled by defining DM_ALIGN_CHECK_EN.
module dm_port_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

  logic             cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsel_q, rpend_q, rpend_d, rerr_q, err_q;

  logic        gnt0, gnt1, any, sel;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  logic        is_read, illegal;

  // Round-robin grant with burst limit; nothing is granted while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (m0_req && m1_req) begin
        if (cnt_q != '0 && cnt_q < MaxCnt) begin
          gnt0 = ~cur_q;
          gnt1 = cur_q;
        end else begin
          gnt0 = cur_q;
          gnt1 = ~cur_q;
        end
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign any       = gnt0 | gnt1;
  assign sel       = gnt1;
  assign sel_addr  = sel ? m1_addr   : m0_addr;
  assign sel_wdata = sel ? m1_wdata  : m0_wdata;
  assign sel_be    = sel ? m1_byteen : m0_byteen;
  assign is_read   = (sel_be == 4'b0000);

`ifdef DM_ALIGN_CHECK_EN
  logic legal;

  // Legal byte-enable / address-offset combinations.
  always_comb begin
    legal = 1'b0;
    case (sel_be)
      4'b0000, 4'b1111, 4'b0011: legal = (sel_addr[1:0] == 2'b00);
      4'b1100:                   legal = (sel_addr[1:0] == 2'b10);
      4'b0001:                   legal = (sel_addr[1:0] == 2'b00);
      4'b0010:                   legal = (sel_addr[1:0] == 2'b01);
      4'b0100:                   legal = (sel_addr[1:0] == 2'b10);
      4'b1000:                   legal = (sel_addr[1:0] == 2'b11);
      default:                   legal = 1'b0;
    endcase
  end

  assign illegal = any & ~legal;
`else
  assign illegal = 1'b0;
`endif

  assign m0_gnt     = gnt0;
  assign m1_gnt     = gnt1;
  assign mem_addr   = any ? (sel_addr & 32'hffff_fffc) : 32'h0;
  assign mem_wdata  = any ? sel_wdata : 32'h0;
  assign mem_byteen = (any && !illegal) ? sel_be : 4'b0000;
  assign mem_rd     = any & ~illegal & is_read;

  // Next-state for arbitration history: saturating burst count per master.
  always_comb begin
    cur_d = cur_q;
    cnt_d = cnt_q;
    if (!any) begin
      cnt_d = '0;
    end else if (sel == cur_q) begin
      if (cnt_q < MaxCnt) cnt_d = cnt_q + 1'b1;
    end else begin
      cur_d = sel;
      cnt_d = CNT_W'(1);
    end
  end

  // An illegal read still returns a beat, just with zeroed data.
  assign rpend_d = any & is_read;

  // State registers; cur resets to 1 so M0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_q   <= 1'b1;
      cnt_q   <= '0;
      rsel_q  <= 1'b0;
      rpend_q <= 1'b0;
      rerr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      rsel_q  <= sel;
      rpend_q <= rpend_d;
      rerr_q  <= illegal;
      err_q   <= illegal;
    end
  end

  // Gating with reset suppresses a return for a read granted just before reset.
  assign m0_rvalid = reset & rpend_q & ~rsel_q;
  assign m1_rvalid = reset & rpend_q & rsel_q;
  assign m0_rdata  = (m0_rvalid && !rerr_q) ? mem_rdata : 32'h0;
  assign m1_rdata  = (m1_rvalid && !rerr_q) ? mem_rdata : 32'h0;
  assign err       = reset & err_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;
  logic        mem_rd, err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_byteen  (m0_byteen),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_byteen  (m1_byteen),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Apply one cycle of inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic rst,
                       input logic r0, input logic [3:0] be0, input logic [31:0] a0,
                       input logic r1, input logic [3:0] be1, input logic [31:0] a1,
                       input logic [31:0] rd);
    @(negedge clk);
    reset     = rst;
    m0_req    = r0;
    m0_byteen = be0;
    m0_addr   = a0;
    m1_req    = r1;
    m1_byteen = be1;
    m1_addr   = a1;
    mem_rdata = rd;
    #1;
  endtask

  logic [11:0] burst_m0_req;
  logic [11:0] burst_exp_g1;

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_byteen = '0; m1_byteen = '0;
    m0_wdata = 32'hDEADBEEF; m1_wdata = 32'h5A5A5A5A;
    mem_rdata = '0;

    // Reset held with M0 requesting: nothing granted.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 4'hF, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
      check("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
      check("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
      check("rst_byteen", {28'b0, mem_byteen}, 32'd0);
      check("rst_rd", {31'b0, mem_rd}, 32'd0);
    end

    // Release: M0 word write.
    drive(1'b1, 1'b1, 4'hF, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
    check("wr_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    check("wr_byteen", {28'b0, mem_byteen}, 32'hF);
    check("wr_addr", mem_addr, 32'h10);
    check("wr_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_rd", {31'b0, mem_rd}, 32'd0);

    // M0 read of the same word.
    drive(1'b1, 1'b1, 4'h0, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
    check("rd_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    check("rd_mem_rd", {31'b0, mem_rd}, 32'd1);
    check("rd_byteen", {28'b0, mem_byteen}, 32'd0);
    check("wr_no_rvalid", {31'b0, m0_rvalid}, 32'd0);

    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF);
    check("rd_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    check("idle_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    check("idle_addr", mem_addr, 32'd0);

    // M1 back-to-back reads, fully pipelined.
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0);
    check("p_gnt0", {31'b0, m1_gnt}, 32'd1);
    check("p_rvalid_idle", {31'b0, m0_rvalid}, 32'd0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h44, 32'h11111111);
    check("p_gnt1", {31'b0, m1_gnt}, 32'd1);
    check("p_addr1", mem_addr, 32'h44);
    check("p_rvalid0", {31'b0, m1_rvalid}, 32'd1);
    check("p_rdata0", m1_rdata, 32'h11111111);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h22222222);
    check("p_rvalid1", {31'b0, m1_rvalid}, 32'd1);
    check("p_rdata1", m1_rdata, 32'h22222222);
    check("p_m0_rdata", m0_rdata, 32'd0);

    // Ties after reset alternate M0, M1, M0 on each fresh contention.
    drive(1'b0, 1'b1, 4'hF, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0);
    check("tie_rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    drive(1'b1, 1'b1, 4'hF, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0);
    check("tie1", {30'b0, m1_gnt, m0_gnt}, 32'b01);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 4'hF, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0);
    check("tie2", {30'b0, m1_gnt, m0_gnt}, 32'b10);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 4'hF, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0);
    check("tie3", {30'b0, m1_gnt, m0_gnt}, 32'b01);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

    // M1 streams; M0 requests once at a time. Bit i = cycle i.
    burst_m0_req = 12'b0011_1101_1110;
    burst_exp_g1 = 12'b1101_1110_1111;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, burst_m0_req[i], 4'hF, 32'h100, 1'b1, 4'hF, 32'h200, 32'h0);
      check($sformatf("burst%0d_g1", i), {31'b0, m1_gnt}, {31'b0, burst_exp_g1[i]});
      check($sformatf("burst%0d_g0", i), {31'b0, m0_gnt},
            {31'b0, burst_m0_req[i] & ~burst_exp_g1[i]});
    end
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Read granted, then reset: no return.
    drive(1'b1, 1'b1, 4'h0, 32'h30, 1'b0, 4'h0, 32'h0, 32'h0);
    check("rr_gnt", {31'b0, m0_gnt}, 32'd1);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h77777777);
    check("rr_rvalid0", {31'b0, m0_rvalid}, 32'd0);
    check("rr_rdata0", m0_rdata, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h77777777);
    check("rr_rvalid1", {31'b0, m0_rvalid}, 32'd0);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Misaligned word write from M1, then misaligned read from M0.
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h22, 32'h0);
    check("al_gnt", {31'b0, m1_gnt}, 32'd1);
`ifdef DM_ALIGN_CHECK_EN
    check("al_byteen", {28'b0, mem_byteen}, 32'd0);
`else
    check("al_byteen", {28'b0, mem_byteen}, 32'hF);
    check("al_addr", mem_addr, 32'h20);
`endif
    drive(1'b1, 1'b1, 4'h0, 32'h21, 1'b0, 4'h0, 32'h0, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
    check("al_err", {31'b0, err}, 32'd1);
    check("al_rd_mem_rd", {31'b0, mem_rd}, 32'd0);
`else
    check("al_err", {31'b0, err}, 32'd0);
    check("al_rd_mem_rd", {31'b0, mem_rd}, 32'd1);
`endif
    drive(1'b1, 1'b1, 4'b0100, 32'h22, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D);
    check("al_rd_rvalid", {31'b0, m0_rvalid}, 32'd1);
`ifdef DM_ALIGN_CHECK_EN
    check("al_rd_err", {31'b0, err}, 32'd1);
    check("al_rd_rdata", m0_rdata, 32'd0);
`else
    check("al_rd_err", {31'b0, err}, 32'd0);
    check("al_rd_rdata", m0_rdata, 32'hCAFEF00D);
`endif
    check("al_byte_ok", {28'b0, mem_byteen}, 32'b0100);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("al_byte_noerr", {31'b0, err}, 32'd0);
    check("al_byte_norv", {31'b0, m0_rvalid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
